// File: rtl/prog_loader.sv
// Program-memory loader: takes a length-prefixed byte stream, writes 18-bit
// instructions through a one-cycle write port, and checks an XOR checksum.
module prog_loader #(
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic [7:0]        RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    output logic              WE,
    output logic [ADDR_W-1:0] WADDR,
    output logic [17:0]       WDATA,
    output logic              CPU_HOLD,
    output logic              DONE,
    output logic              ERR
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_B0, S_B1, S_B2,
        S_WRITE, S_CHK, S_DONE, S_ERROR
    } state_t;

    state_t            state_reg, state_next;
    logic [9:0]        len_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [7:0]        chk_reg;
    logic [1:0]        b0_reg;
    logic [7:0]        b1_reg;
    logic [TW-1:0]     timer_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [17:0]       wdata_reg;

    logic rx_ready;
    logic accept;
    logic start_ok;
    logic timed_out;
    logic last_word;

    always_comb begin
        rx_ready = (state_reg == S_LEN_HI) || (state_reg == S_LEN_LO) ||
                   (state_reg == S_B0)     || (state_reg == S_B1)     ||
                   (state_reg == S_B2)     || (state_reg == S_CHK);
        accept    = RX_VALID && rx_ready;
        start_ok  = START && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                              (state_reg == S_ERROR));
        timed_out = rx_ready && !accept && (timer_reg == TW'(TIMEOUT_CYCLES - 1));
        // Frame ends once the word just written was word N-1.
        last_word = ((32'(addr_reg) + 32'd1) == 32'(len_reg));
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_reg <= S_IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (start_ok) begin
            state_next = S_LEN_HI;
        end else if (timed_out) begin
            state_next = S_ERROR;
        end else begin
            unique case (state_reg)
                S_LEN_HI: if (accept) state_next = S_LEN_LO;
                S_LEN_LO: if (accept) state_next = ({len_reg[9:8], RX_DATA} == 10'd0) ? S_CHK : S_B0;
                S_B0:     if (accept) state_next = S_B1;
                S_B1:     if (accept) state_next = S_B2;
                S_B2:     if (accept) state_next = S_WRITE;
                S_WRITE:  state_next = last_word ? S_CHK : S_B0;
                S_CHK:    if (accept) state_next = (RX_DATA == chk_reg) ? S_DONE : S_ERROR;
                default:  state_next = state_reg;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            len_reg   <= '0;
            addr_reg  <= '0;
            chk_reg   <= '0;
            b0_reg    <= '0;
            b1_reg    <= '0;
            timer_reg <= '0;
            waddr_reg <= '0;
            wdata_reg <= '0;
        end else if (start_ok) begin
            addr_reg  <= '0;
            chk_reg   <= '0;
            timer_reg <= '0;
        end else begin
            if (accept)
                timer_reg <= '0;
            else if (rx_ready)
                timer_reg <= timer_reg + 1'b1;

            if (accept) begin
                unique case (state_reg)
                    S_LEN_HI: len_reg[9:8] <= RX_DATA[1:0];
                    S_LEN_LO: len_reg[7:0] <= RX_DATA;
                    S_B0: begin
                        b0_reg  <= RX_DATA[1:0];
                        chk_reg <= chk_reg ^ RX_DATA;
                    end
                    S_B1: begin
                        b1_reg  <= RX_DATA;
                        chk_reg <= chk_reg ^ RX_DATA;
                    end
                    S_B2: begin
                        // Output registers load here so WADDR/WDATA stay put between writes.
                        chk_reg   <= chk_reg ^ RX_DATA;
                        wdata_reg <= {b0_reg, b1_reg, RX_DATA};
                        waddr_reg <= addr_reg;
                    end
                    default: ;
                endcase
            end

            if (state_reg == S_WRITE)
                addr_reg <= addr_reg + 1'b1;
        end
    end

    assign RX_READY = rx_ready;
    assign WE       = (state_reg == S_WRITE);
    assign WADDR    = waddr_reg;
    assign WDATA    = wdata_reg;
    assign CPU_HOLD = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign DONE     = (state_reg == S_DONE);
    assign ERR      = (state_reg == S_ERROR);

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of whole frames with expected writes and flags,
// plus hand-written timeout and mid-load reset sequences.
module tb_prog_loader;

    localparam int ADDR_W = 10;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              START = 1'b0;
    logic [7:0]        RX_DATA = 8'h00;
    logic              RX_VALID = 1'b0;
    logic              RX_READY;
    logic              WE;
    logic [ADDR_W-1:0] WADDR;
    logic [17:0]       WDATA;
    logic              CPU_HOLD;
    logic              DONE;
    logic              ERR;

    prog_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .WE(WE), .WADDR(WADDR), .WDATA(WDATA),
        .CPU_HOLD(CPU_HOLD), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int acc_cnt = 0;
    logic [ADDR_W+17:0] we_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Write and accept monitor, sampled on the falling edge.
    always @(negedge CLK) begin
        if (!RST && WE) begin
            we_q.push_back({WADDR, WDATA});
            chk("ready_low_in_write", 32'(RX_READY), 32'd0);
        end
        if (!RST && RX_VALID && RX_READY)
            acc_cnt++;
    end

    typedef struct packed {
        logic [7:0]          nb;
        logic [0:15][7:0]    b;
        logic [2:0]          nw;
        logic [0:3][17:0]    w;
        logic                done;
        logic                err;
        logic                hold;
    } vec_t;

    vec_t vecs [0:5];

    task automatic pulse_start();
        START = 1'b1;
        @(posedge CLK); #1;
        START = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        RX_DATA  = b;
        RX_VALID = 1'b1;
        n = 0;
        @(negedge CLK);
        while (!RX_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (!RX_READY) begin
            chk("rx_ready_wait", 32'd0, 32'd1);
        end else begin
            @(posedge CLK); #1;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        we_q.delete();
        acc_cnt = 0;
        pulse_start();
        for (int i = 0; i < int'(v.nb); i++)
            send_byte(v.b[i]);
        RX_VALID = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        $display("vec %0d: bytes=%0d writes=%0d done=%0b err=%0b hold=%0b",
                 idx, acc_cnt, we_q.size(), DONE, ERR, CPU_HOLD);
        chk("accepted_bytes", 32'(acc_cnt), 32'(v.nb));
        chk("write_count", 32'(we_q.size()), 32'(v.nw));
        for (int i = 0; i < int'(v.nw) && i < we_q.size(); i++) begin
            chk("waddr", 32'(we_q[i][ADDR_W+17:18]), 32'(i));
            chk("wdata", 32'(we_q[i][17:0]), 32'(v.w[i]));
        end
        chk("done", 32'(DONE), 32'(v.done));
        chk("err", 32'(ERR), 32'(v.err));
        chk("cpu_hold", 32'(CPU_HOLD), 32'(v.hold));
    endtask

    initial begin
        // Two words, good checksum 0x64.
        vecs[0].nb = 8'd9;
        vecs[0].b  = {8'h00, 8'h02, 8'h03, 8'hFF, 8'hFF, 8'h01, 8'h23, 8'h45, 8'h64, 56'h0};
        vecs[0].nw = 3'd2;
        vecs[0].w  = {18'h3FFFF, 18'h12345, 36'h0};
        vecs[0].done = 1'b1; vecs[0].err = 1'b0; vecs[0].hold = 1'b0;
        // Same words, bad checksum.
        vecs[1] = vecs[0];
        vecs[1].b[8] = 8'h65;
        vecs[1].done = 1'b0; vecs[1].err = 1'b1; vecs[1].hold = 1'b1;
        // Restart from ERROR with the good frame.
        vecs[2] = vecs[0];
        // Empty frame, checksum 0.
        vecs[3].nb = 8'd3;
        vecs[3].b  = {8'h00, 8'h00, 8'h00, 104'h0};
        vecs[3].nw = 3'd0;
        vecs[3].w  = '0;
        vecs[3].done = 1'b1; vecs[3].err = 1'b0; vecs[3].hold = 1'b0;
        // Empty frame, bad checksum.
        vecs[4] = vecs[3];
        vecs[4].b[2] = 8'h07;
        vecs[4].done = 1'b0; vecs[4].err = 1'b1; vecs[4].hold = 1'b1;
        // Three words; LEN_HI upper bits and B0 upper bits must be ignored.
        vecs[5].nb = 8'd12;
        vecs[5].b  = {8'hFC, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFC, 8'hAA, 8'h55,
                      8'h02, 8'h00, 8'hFF, 8'hFE, 32'h0};
        vecs[5].nw = 3'd3;
        vecs[5].w  = {18'h10203, 18'h0AA55, 18'h200FF, 18'h0};
        vecs[5].done = 1'b1; vecs[5].err = 1'b0; vecs[5].hold = 1'b0;

        repeat (2) @(posedge CLK);
        #1;
        chk("reset_ready", 32'(RX_READY), 32'd0);
        chk("reset_we", 32'(WE), 32'd0);
        chk("reset_hold", 32'(CPU_HOLD), 32'd0);
        chk("reset_done", 32'(DONE), 32'd0);
        chk("reset_err", 32'(ERR), 32'd0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("idle_ready", 32'(RX_READY), 32'd0);

        for (int k = 0; k < 6; k++)
            run_vec(k, vecs[k]);

        // Timeout: 15 idle cycles are tolerated, the 16th errors out.
        we_q.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h01);
        send_byte(8'h03);
        RX_VALID = 1'b0;
        repeat (15) begin @(posedge CLK); #1; end
        chk("timeout_not_yet", 32'(ERR), 32'd0);
        @(posedge CLK); #1;
        $display("timeout: err=%0b hold=%0b writes=%0d", ERR, CPU_HOLD, we_q.size());
        chk("timeout_err", 32'(ERR), 32'd1);
        chk("timeout_hold", 32'(CPU_HOLD), 32'd1);
        chk("timeout_no_we", 32'(we_q.size()), 32'd0);

        // Asynchronous reset while in B1 of word 5.
        we_q.delete();
        pulse_start();
        send_byte(8'h00);
        send_byte(8'h06);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'h00);
            send_byte(8'h00);
            send_byte(8'(i + 1));
        end
        send_byte(8'h00);
        chk("midload_writes", 32'(we_q.size()), 32'd5);
        chk("midload_hold", 32'(CPU_HOLD), 32'd1);
        chk("midload_waddr", 32'(WADDR), 32'd4);
        #2;
        RST = 1'b1;
        #1;
        $display("async reset: ready=%0b we=%0b waddr=%0d wdata=0x%0h hold=%0b",
                 RX_READY, WE, WADDR, WDATA, CPU_HOLD);
        chk("arst_ready", 32'(RX_READY), 32'd0);
        chk("arst_we", 32'(WE), 32'd0);
        chk("arst_waddr", 32'(WADDR), 32'd0);
        chk("arst_wdata", 32'(WDATA), 32'd0);
        chk("arst_hold", 32'(CPU_HOLD), 32'd0);
        chk("arst_done", 32'(DONE), 32'd0);
        chk("arst_err", 32'(ERR), 32'd0);
        RX_VALID = 1'b0;
        @(posedge CLK); #3;
        RST = 1'b0;
        @(posedge CLK); #1;
        run_vec(6, vecs[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

endmodule
